// File: rtl/educell_spikerecv.sv
// Receive side of the EDU cell spike fabric: samples six neighbour spike inputs,
// arbitrates by fixed priority and records take/hit events plus per-round statistics.
`ifndef EDUCELL_SOURCE
`define EDUCELL_SOURCE 3'd1
`endif
`ifndef EDUCELL_BOUNDARY
`define EDUCELL_BOUNDARY 3'd2
`endif
`ifndef EDUCELL_TRANSMIT
`define EDUCELL_TRANSMIT 3'd3
`endif

module educell_spikerecv #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic             cell_clear,
    input  logic             spike_in_nw,
    input  logic             spike_in_ne,
    input  logic             spike_in_sw,
    input  logic             spike_in_se,
    input  logic             spike_in_n,
    input  logic             spike_in_s,
    output logic             spike_taken,
    output logic [5:0]       spikedir_reg,
    output logic [5:0]       srcdir_reg,
    output logic             taken_flag,
    output logic             spike_hit,
    output logic             hit_valid,
    output logic [5:0]       hit_dir,
    output logic             spike_drop,
    output logic [CNT_W-1:0] spike_cnt
);

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_HIT,
        MODE_TX
    } mode_t;

    mode_t      mode;
    logic [5:0] in_vec;
    logic       any_in;
    logic [5:0] sel;
    logic [5:0] fwd_mask;

    assign in_vec = {spike_in_nw, spike_in_ne, spike_in_sw, spike_in_se, spike_in_n, spike_in_s};
    assign any_in = |in_vec;

    always_comb begin
        mode = MODE_IDLE;
        case (state)
            `EDUCELL_SOURCE,
            `EDUCELL_BOUNDARY: mode = MODE_HIT;
            `EDUCELL_TRANSMIT: mode = MODE_TX;
            default:           mode = MODE_IDLE;
        endcase
    end

    // Fixed priority nw > ne > sw > se > n > s.
    always_comb begin
        sel = '0;
        if (in_vec[5])      sel = 6'b100000;
        else if (in_vec[4]) sel = 6'b010000;
        else if (in_vec[3]) sel = 6'b001000;
        else if (in_vec[2]) sel = 6'b000100;
        else if (in_vec[1]) sel = 6'b000010;
        else if (in_vec[0]) sel = 6'b000001;
    end

    always_comb begin
        fwd_mask = '0;
        case (sel)
            6'b100000: fwd_mask = 6'b000101;
            6'b010000: fwd_mask = 6'b001001;
            6'b001000: fwd_mask = 6'b010010;
            6'b000100: fwd_mask = 6'b100010;
            6'b000010: fwd_mask = 6'b001101;
            6'b000001: fwd_mask = 6'b110010;
            default:   fwd_mask = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_taken  <= 1'b0;
            spikedir_reg <= '0;
            srcdir_reg   <= '0;
            taken_flag   <= 1'b0;
            spike_hit    <= 1'b0;
            hit_valid    <= 1'b0;
            hit_dir      <= '0;
            spike_drop   <= 1'b0;
            spike_cnt    <= '0;
        end else begin
            spike_taken <= 1'b0;
            spike_hit   <= 1'b0;
            spike_drop  <= 1'b0;
            // Clear wins over a same-cycle arrival, which is discarded uncounted.
            if (cell_clear) begin
                spikedir_reg <= '0;
                srcdir_reg   <= '0;
                taken_flag   <= 1'b0;
                hit_valid    <= 1'b0;
                hit_dir      <= '0;
                spike_cnt    <= '0;
            end else if (mode != MODE_IDLE && any_in) begin
                if (spike_cnt != '1) spike_cnt <= spike_cnt + 1'b1;
                if (mode == MODE_TX) begin
                    if (!taken_flag) begin
                        taken_flag   <= 1'b1;
                        srcdir_reg   <= sel;
                        spikedir_reg <= fwd_mask;
                        spike_taken  <= 1'b1;
                    end else begin
                        spike_drop <= 1'b1;
                    end
                end else begin
                    if (!hit_valid) begin
                        hit_valid <= 1'b1;
                        hit_dir   <= sel;
                        spike_hit <= 1'b1;
                    end else begin
                        spike_drop <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/educell_spikerecv.md
Name: educell_spikerecv

Overview:
Receive side of the EDU cell spike fabric. Samples the six directional spike inputs driven by neighbouring cells' spike generators and arbitrates simultaneous arrivals. In TRANSMIT state it produces the registered spike_taken pulse and spikedir_reg forwarding mask that this cell's own spike generator consumes. In SOURCE/BOUNDARY state it records hit events that terminate a spike path, keeps per-round drop and arrival statistics, and clears on a per-round synchronous clear.

Parameters:
CNT_W, 4, width of saturating arrival counter spike_cnt.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
state  input  3  cell state; `EDUCELL_SOURCE`, `EDUCELL_BOUNDARY`, `EDUCELL_TRANSMIT` defined; any other code = inactive.
cell_clear  input  1  synchronous per-round clear.
spike_in_nw/ne/sw/se/n/s  input  1 each  spike arriving from neighbour at that direction.
spike_taken  output  1  one-cycle pulse: spike accepted in TRANSMIT.
spikedir_reg  output  6  forwarding mask {nw,ne,sw,se,n,s} (bit5..bit0).
srcdir_reg  output  6  one-hot origin direction of accepted spike.
taken_flag  output  1  sticky: spike accepted this round.
spike_hit  output  1  one-cycle pulse: spike reached SOURCE/BOUNDARY cell.
hit_valid  output  1  sticky: hit recorded this round.
hit_dir  output  6  one-hot direction of first hit.
spike_drop  output  1  one-cycle pulse: arrival ignored because already taken/hit.
spike_cnt  output  CNT_W  saturating count of arrival cycles this round.

Behaviour:
- rst low (async): every output and internal register = 0.
- in_vec = {nw,ne,sw,se,n,s}; any_in = |in_vec. Fixed priority nw>ne>sw>se>n>s selects one-hot sel.
- Forward map (sel -> mask): nw->{se,s}=6'b000101; ne->{sw,s}=6'b001001; sw->{ne,n}=6'b010010; se->{nw,n}=6'b100010; n->{sw,se,s}=6'b001101; s->{nw,ne,n}=6'b110010.
- TRANSMIT, any_in, taken_flag=0: next edge sets taken_flag=1, srcdir_reg=sel, spikedir_reg=map(sel), spike_taken=1 for exactly one cycle. Latency: input cycle N -> pulse and mask visible cycle N+1.
- TRANSMIT, any_in, taken_flag=1: no register change except spike_drop=1 for one cycle.
- SOURCE or BOUNDARY, any_in, hit_valid=0: next edge sets hit_valid=1, hit_dir=sel, spike_hit pulse one cycle. With hit_valid=1: spike_drop pulse only.
- Inactive state: inputs ignored entirely; no pulses, no count.
- spike_cnt: +1 each edge where any_in and state active; saturates at 2^CNT_W-1 (no wrap).
- spikedir_reg, srcdir_reg, hit_dir hold until cell_clear or reset. taken_flag/hit_valid persist across state changes.
- cell_clear=1: next edge clears all sticky registers, masks, counter, pulses; overrides a same-cycle arrival (arrival discarded, not counted).
- Pulses (spike_taken, spike_hit, spike_drop) are registered, never combinational from inputs; default 0 each cycle.
- Reset deassert mid-round: block restarts from cleared state; no spurious pulse on first edge.

Test Plan:
- Reset: rst low with random inputs/state -> all outputs 0; release, idle 3 cycles -> still 0.
- TRANSMIT, spike_in_sw=1 one cycle N -> cycle N+1 spike_taken=1, spikedir_reg=6'b010010, srcdir_reg=6'b001000, taken_flag=1; N+2 spike_taken=0, mask held, spike_cnt=1.
- TRANSMIT, spike_in_ne and spike_in_s simultaneous -> srcdir_reg=6'b010000, spikedir_reg=6'b001001; next cycle spike_in_n=1 -> spike_drop pulse, mask unchanged, spike_cnt=2.
- BOUNDARY, spike_in_n=1 -> spike_hit pulse, hit_dir=6'b000010, hit_valid=1, spike_taken stays 0; state -> TRANSMIT, spike_in_s -> spike_taken pulse (taken_flag independent of hit_valid).
- CNT_W=2: 5 consecutive arrival cycles in TRANSMIT -> spike_cnt=3 saturated; cell_clear with concurrent spike_in_nw -> next cycle all outputs 0, no spike_taken.
- Inactive state code with spike_in_se=1 -> no pulses, spike_cnt unchanged.
